tx_frac_baud_generator: RTL and testbench
=========================================

TX_FRAC_BAUD_GENERATOR -- requirements
Module: tx_frac_baud_generator

Interface
REQ-001 SHALL have parameter TX_SYS_CLK, default 50_000_000, meaning the system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning the reset-time baud rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, meaning oversample ticks per bit; legal values are 1, 8 and 16.
REQ-004 SHALL have parameter INT_W, default 16, meaning the divisor integer width.
REQ-005 SHALL have parameter FRAC_W, default 4, meaning the divisor fraction width in 1/2^FRAC_W units.
REQ-006 SHALL have port tx_clk, input, width 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, width 1, the asynchronous active-high reset.
REQ-008 SHALL have port baud_gen_en, input, width 1; 1 = run, 0 = hold in restart state.
REQ-009 SHALL have port div_load, input, width 1, a one-cycle request to load a new divisor.
REQ-010 SHALL have port div_int, input, width INT_W, the integer part of the clocks-per-oversample-tick divisor.
REQ-011 SHALL have port div_frac, input, width FRAC_W, the fractional part of the divisor.
REQ-012 SHALL have port div_err, output, width 1, a one-cycle pulse when a load is rejected.
REQ-013 SHALL have port os_tick, output, width 1, the oversample tick pulse.
REQ-014 SHALL have port tx_tick, output, width 1, the bit-rate tick pulse.
REQ-015 SHALL register every output.

Function
REQ-016 Divisor: SHALL keep an active pair {act_int, act_frac}.
REQ-017 Divisor reset value: SHALL be DEF_INT = floor(TX_SYS_CLK/(BAUD_RATE*OVERSAMPLE)).
REQ-018 Divisor reset value: SHALL be DEF_FRAC = round of the fractional remainder × 2^FRAC_W; a result of 2^FRAC_W SHALL saturate to 2^FRAC_W−1.
REQ-019 Load acceptance: div_load with div_int ≥ 2 SHALL be captured into a shadow pair on that edge.
REQ-020 Load rejection: div_load with div_int < 2 SHALL leave shadow unchanged and SHALL pulse div_err high for exactly 1 cycle on the next edge.
REQ-021 Shadow→active: SHALL transfer at the next os_tick boundary (same edge that asserts os_tick), or immediately while baud_gen_en=0; no period ever mixes old and new divisors.
REQ-022 Back-to-back loads: a second load before transfer SHALL overwrite the shadow; last accepted wins.
REQ-023 Period generation: each oversample period SHALL last act_int + c clocks.
REQ-024 Fraction carry: c = carry-out of frac_acc + act_frac (FRAC_W-bit sum, wrap-around); frac_acc SHALL update once per period.
REQ-025 Fraction average: over 2^FRAC_W periods the total clock count SHALL be exactly 2^FRAC_W·act_int + act_frac.
REQ-026 Counter: SHALL count clocks from 0 to period−1; os_tick SHALL be high for exactly one cycle per period, never two consecutive cycles.
REQ-027 Latency: with baud_gen_en rising before edge 0, the first os_tick SHALL be high after edge act_int+c−1, i.e. a full period, not immediately.
REQ-028 Phase counter: a counter 0..OVERSAMPLE−1 SHALL advance on each os_tick.
REQ-029 tx_tick: SHALL assert in the same cycle as the os_tick that wraps the phase counter, for one cycle; with OVERSAMPLE=1, tx_tick ≡ os_tick.
REQ-030 Disable: baud_gen_en=0 SHALL synchronously clear the counter, phase and frac_acc, and force os_tick=tx_tick=0 on the next edge.
REQ-031 Disable mid-period: SHALL produce no partial tick; re-enable restarts per REQ-027.
REQ-032 Simultaneous load and boundary: div_load on the boundary edge SHALL go to shadow only; it becomes active at the following boundary.

Reset
REQ-033 rst high SHALL asynchronously force: counter=0, phase=0, frac_acc=0, os_tick=0, tx_tick=0, div_err=0, shadow=active={DEF_INT, DEF_FRAC}.
REQ-034 Reset release SHALL be safe on any edge; the first period after release SHALL be full length.
REQ-035 Reset mid-operation SHALL discard any pending shadow load.

Structure
REQ-036 Shared package uart_pkg SHALL hold the OVERSAMPLE legal-value constants, the DEF_INT/DEF_FRAC computation function, and the divisor width localparams.
REQ-037 Counter width SHALL be INT_W + 1, to hold act_int + carry without overflow.
REQ-038 One sub-module, baud_frac_acc, SHALL own frac_acc and produce c per period; top SHALL own counter, phase, shadow/active and outputs.
REQ-039 An illegal OVERSAMPLE SHALL cause an elaboration-time error.

Verification
REQ-040 Defaults (50 MHz, 9600, OS=16): DEF_INT=325, DEF_FRAC=8; over 16 periods SHALL total 5208 clocks, as 8 periods of 325 and 8 of 326 alternating; tx_tick every 16th os_tick.
REQ-041 Load div_int=10, div_frac=0 mid-period: current period SHALL finish at old length, then os_tick spacing SHALL be exactly 10 clocks.
REQ-042 Load div_int=1: div_err SHALL be one-cycle high next edge, and tick spacing SHALL be unchanged; load div_int=2, div_frac=0 with OS=1 SHALL give tx_tick every 2 clocks, never high twice in a row.
REQ-043 Drop baud_gen_en 5 clocks into a period, hold 20 clocks, re-raise: no tick while low; first os_tick one full period after re-enable; phase restarts at 0.
REQ-044 Assert rst asynchronously mid-period after a pending load: outputs SHALL be 0 immediately, and post-release spacing SHALL equal the defaults, not the pending divisor.
REQ-045 div_load coincident with an os_tick edge: new divisor SHALL take effect one period later, per REQ-032.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and helpers. Holds the legal oversample
//               ratios, the default divisor widths and minimum divisor, and
//               the functions that derive the reset-time divisor
//               {DEF_INT, DEF_FRAC} from clock frequency, baud rate and
//               oversample ratio.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Legal oversample ratios
    localparam int unsigned c_os_x1  = 1;
    localparam int unsigned c_os_x8  = 8;
    localparam int unsigned c_os_x16 = 16;

    // Divisor widths: integer clocks-per-tick and fraction in 1/2^FRAC_W units
    localparam int unsigned c_div_int_w  = 16;
    localparam int unsigned c_div_frac_w = 4;

    // Smallest integer divisor that still leaves a non-tick cycle between
    // consecutive ticks
    localparam int unsigned c_min_div_int = 2;

    function automatic bit os_is_legal(input int unsigned os);
        return (os == c_os_x1) || (os == c_os_x8) || (os == c_os_x16);
    endfunction

    // Integer part: floor(sys_clk / (baud * os))
    function automatic longint unsigned calc_def_int(
        input longint unsigned sys_clk,
        input longint unsigned baud,
        input longint unsigned os
    );
        return sys_clk / (baud * os);
    endfunction

    // Fractional part: remainder scaled by 2^frac_w and rounded to nearest.
    // Rounding can reach 2^frac_w, which does not fit, so it saturates.
    function automatic longint unsigned calc_def_frac(
        input longint unsigned sys_clk,
        input longint unsigned baud,
        input longint unsigned os,
        input int unsigned     frac_w
    );
        longint unsigned divisor;
        longint unsigned rem;
        longint unsigned full;
        longint unsigned scaled;
        divisor = baud * os;
        rem     = sys_clk % divisor;
        full    = 64'd1 << frac_w;
        scaled  = (rem * full + divisor / 64'd2) / divisor;
        if (scaled >= full) begin
            scaled = full - 64'd1;
        end
        return scaled;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/baud_frac_acc.sv
`default_nettype none
// ============================================================================
// Module      : baud_frac_acc
// Description : Fractional divisor accumulator. Holds frac_acc and presents
//               the carry-out of frac_acc + frac for the period currently in
//               progress. The accumulator advances once per period, on the
//               boundary edge, so the carry is stable for a whole period.
// Ports       : i_clk   - clock (rising edge)
//               i_rst   - asynchronous active-high reset
//               i_clr   - synchronous clear (generator disabled)
//               i_adv   - advance accumulator (period boundary)
//               i_frac  - active fractional divisor
//               o_carry - one extra clock for the current period
// Revision    : 1.0 - initial release
// ============================================================================
module baud_frac_acc #(
    parameter int unsigned FRAC_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_adv,
    input  logic [FRAC_W-1:0] i_frac,
    output logic              o_carry
);

    logic [FRAC_W-1:0] r_acc;
    logic [FRAC_W:0]   w_sum;

    // Wrap-around sum; the MSB is the carry that lengthens this period
    assign w_sum   = {1'b0, r_acc} + {1'b0, i_frac};
    assign o_carry = w_sum[FRAC_W];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_adv) begin
            r_acc <= w_sum[FRAC_W-1:0];
        end
    end

endmodule : baud_frac_acc
`default_nettype wire

// File: rtl/tx_frac_baud_generator.sv
`default_nettype none
// ============================================================================
// Module      : tx_frac_baud_generator
// Description : Fractional-N baud tick generator. Produces an oversample tick
//               (os_tick) whose period is act_int or act_int+1 clocks, so
//               that 2^FRAC_W periods total exactly 2^FRAC_W*act_int +
//               act_frac clocks, and a bit tick (tx_tick) on every
//               OVERSAMPLE-th os_tick. New divisors are staged in a shadow
//               pair and only become active on a period boundary.
// Ports       : tx_clk      - clock (rising edge)
//               rst         - asynchronous active-high reset
//               baud_gen_en - 1 = run, 0 = hold in restart state
//               div_load    - one-cycle request to load div_int/div_frac
//               div_int     - integer clocks per oversample tick
//               div_frac    - fractional clocks per tick, 1/2^FRAC_W units
//               div_err     - one-cycle pulse when a load is rejected
//               os_tick     - oversample tick, one cycle per period
//               tx_tick     - bit tick, coincident with a phase-wrapping
//                             os_tick
// Revision    : 1.0 - initial release
// ============================================================================
module tx_frac_baud_generator
    import uart_pkg::*;
#(
    parameter int unsigned TX_SYS_CLK = 50_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned INT_W      = c_div_int_w,
    parameter int unsigned FRAC_W     = c_div_frac_w
) (
    input  logic              tx_clk,
    input  logic              rst,
    input  logic              baud_gen_en,
    input  logic              div_load,
    input  logic [INT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              div_err,
    output logic              os_tick,
    output logic              tx_tick
);

    // ------------------------------------------------------------------------
    // Elaboration-time checks
    // ------------------------------------------------------------------------
    generate
        if (!os_is_legal(OVERSAMPLE)) begin : g_os_illegal
            $error("tx_frac_baud_generator: OVERSAMPLE must be 1, 8 or 16");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // One spare bit so act_int + carry never overflows
    localparam int unsigned c_cnt_w = INT_W + 1;
    localparam int unsigned c_ph_w  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [INT_W-1:0] c_def_int = INT_W'(calc_def_int(
        64'(TX_SYS_CLK), 64'(BAUD_RATE), 64'(OVERSAMPLE)));
    localparam logic [FRAC_W-1:0] c_def_frac = FRAC_W'(calc_def_frac(
        64'(TX_SYS_CLK), 64'(BAUD_RATE), 64'(OVERSAMPLE), FRAC_W));

    localparam logic [INT_W-1:0]  c_min_int  = INT_W'(c_min_div_int);
    localparam logic [c_ph_w-1:0] c_ph_last  = c_ph_w'(OVERSAMPLE - 1);

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_ph_w-1:0]  r_phase;
    logic [INT_W-1:0]   r_shd_int;
    logic [FRAC_W-1:0]  r_shd_frac;
    logic [INT_W-1:0]   r_act_int;
    logic [FRAC_W-1:0]  r_act_frac;
    logic               r_os_tick;
    logic               r_tx_tick;
    logic               r_div_err;

    logic               w_carry;
    logic [c_cnt_w-1:0] w_period;
    logic [c_cnt_w-1:0] w_last;
    logic               w_boundary;
    logic               w_load_ok;
    logic               w_load_bad;
    logic               w_ph_wrap;

    // ------------------------------------------------------------------------
    // Fraction accumulator
    // ------------------------------------------------------------------------
    baud_frac_acc #(
        .FRAC_W (FRAC_W)
    ) u_frac_acc (
        .i_clk   (tx_clk),
        .i_rst   (rst),
        .i_clr   (!baud_gen_en),
        .i_adv   (w_boundary),
        .i_frac  (r_act_frac),
        .o_carry (w_carry)
    );

    // ------------------------------------------------------------------------
    // Period decode
    // ------------------------------------------------------------------------
    // The carry and the active divisor only change on the boundary edge, so
    // the period length is fixed for the whole period.
    assign w_period   = {1'b0, r_act_int} + {{INT_W{1'b0}}, w_carry};
    assign w_last     = w_period - c_cnt_w'(1);
    assign w_boundary = baud_gen_en && (r_cnt == w_last);
    assign w_ph_wrap  = (r_phase == c_ph_last);

    assign w_load_ok  = div_load && (div_int >= c_min_int);
    assign w_load_bad = div_load && (div_int <  c_min_int);

    // ------------------------------------------------------------------------
    // Counter, phase and tick outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_phase   <= '0;
            r_os_tick <= 1'b0;
            r_tx_tick <= 1'b0;
        end else if (!baud_gen_en) begin
            r_cnt     <= '0;
            r_phase   <= '0;
            r_os_tick <= 1'b0;
            r_tx_tick <= 1'b0;
        end else if (w_boundary) begin
            r_cnt     <= '0;
            r_os_tick <= 1'b1;
            r_tx_tick <= w_ph_wrap;
            r_phase   <= w_ph_wrap ? '0 : (r_phase + c_ph_w'(1));
        end else begin
            r_cnt     <= r_cnt + c_cnt_w'(1);
            r_os_tick <= 1'b0;
            r_tx_tick <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Shadow / active divisor
    // ------------------------------------------------------------------------
    // On the boundary edge the active pair takes the shadow value as it was
    // before this edge, so a load landing on the boundary waits one more
    // period. While disabled there is no period in flight, so an accepted
    // load goes straight to the active pair.
    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            r_shd_int  <= c_def_int;
            r_shd_frac <= c_def_frac;
            r_act_int  <= c_def_int;
            r_act_frac <= c_def_frac;
        end else begin
            if (w_load_ok) begin
                r_shd_int  <= div_int;
                r_shd_frac <= div_frac;
            end
            if (!baud_gen_en) begin
                r_act_int  <= w_load_ok ? div_int  : r_shd_int;
                r_act_frac <= w_load_ok ? div_frac : r_shd_frac;
            end else if (w_boundary) begin
                r_act_int  <= r_shd_int;
                r_act_frac <= r_shd_frac;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Load rejection flag
    // ------------------------------------------------------------------------
    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            r_div_err <= 1'b0;
        end else begin
            r_div_err <= w_load_bad;
        end
    end

    assign os_tick = r_os_tick;
    assign tx_tick = r_tx_tick;
    assign div_err = r_div_err;

endmodule : tx_frac_baud_generator
`default_nettype wire

// File: tb/tb_tx_frac_baud_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_frac_baud_generator
// Description : Self-checking bench for tx_frac_baud_generator. Expected
//               oversample periods come from a small fractional-divisor model
//               and are queued as stimulus is applied, then popped as the DUT
//               produces each os_tick. A second instance with OVERSAMPLE=1
//               covers the minimum-divisor bit tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_frac_baud_generator;

    localparam int OS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, ld;
    logic [15:0] di;
    logic [3:0]  df;
    logic        div_err, os_tick, tx_tick;

    logic        en1, ld1;
    logic [15:0] di1;
    logic [3:0]  df1;
    logic        err1, os1, tx1;

    always #5 clk = ~clk;

    tx_frac_baud_generator dut (
        .tx_clk      (clk),
        .rst         (rst),
        .baud_gen_en (en),
        .div_load    (ld),
        .div_int     (di),
        .div_frac    (df),
        .div_err     (div_err),
        .os_tick     (os_tick),
        .tx_tick     (tx_tick)
    );

    tx_frac_baud_generator #(
        .OVERSAMPLE (1)
    ) dut1 (
        .tx_clk      (clk),
        .rst         (rst),
        .baud_gen_en (en1),
        .div_load    (ld1),
        .div_int     (di1),
        .div_frac    (df1),
        .div_err     (err1),
        .os_tick     (os1),
        .tx_tick     (tx1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the active divisor, fraction accumulator and phase counter
    int m_int, m_frac, m_acc, m_phase;
    int q_exp[$];

    typedef struct {
        int d_int;
        int d_frac;
        bit exp_err;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_next_period();
        int sum;
        int c;
        sum   = m_acc + m_frac;
        c     = (sum >= 16) ? 1 : 0;
        m_acc = sum % 16;
        return m_int + c;
    endfunction

    task automatic push_periods(input int n);
        for (int k = 0; k < n; k++) begin
            q_exp.push_back(model_next_period());
        end
    endtask

    // Pop one expected period per os_tick; the cycle count starts at 'start'
    // clocks already elapsed in the current period. div_load is held for one
    // edge only.
    task automatic drain(input string name, input int start, output int total);
        int cycles;
        int e;
        int exp_tx;
        cycles = start;
        total  = start;
        while (q_exp.size() > 0) begin
            @(negedge clk);
            ld = 1'b0;
            cycles++;
            total++;
            if (tx_tick && !os_tick) check({name, "_tx_alone"}, 1, 0);
            if (os_tick) begin
                e = q_exp.pop_front();
                check({name, "_period"}, cycles, e);
                exp_tx  = (m_phase == OS - 1) ? 1 : 0;
                m_phase = (m_phase + 1) % OS;
                check({name, "_tx"}, int'(tx_tick), exp_tx);
                cycles = 0;
            end else if (cycles > 1000) begin
                check({name, "_timeout"}, cycles, q_exp[0]);
                q_exp.delete();
            end
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tot;
        int p;
        int ticks;

        vecs[0] = '{10, 0,  1'b0};
        vecs[1] = '{7,  3,  1'b0};
        vecs[2] = '{3,  15, 1'b0};
        vecs[3] = '{1,  5,  1'b1};
        vecs[4] = '{0,  0,  1'b1};
        vecs[5] = '{2,  1,  1'b0};
        vecs[6] = '{325, 8, 1'b0};

        rst = 1'b1; en = 1'b0; ld = 1'b0; di = '0; df = '0;
        en1 = 1'b0; ld1 = 1'b0; di1 = '0; df1 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_os_tick", int'(os_tick), 0);
        check("rst_tx_tick", int'(tx_tick), 0);
        check("rst_div_err", int'(div_err), 0);
        rst = 1'b0;

        // OVERSAMPLE=1 with divisor 2: tx_tick every other clock
        @(negedge clk);
        ld1 = 1'b1; di1 = 16'd2; df1 = 4'd0;
        @(negedge clk);
        ld1 = 1'b0; en1 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("os1_tx", int'(tx1), (k % 2 == 0) ? 1 : 0);
            check("os1_os", int'(os1), (k % 2 == 0) ? 1 : 0);
        end
        check("os1_err", int'(err1), 0);
        en1 = 1'b0;

        // Reset-time defaults: 325/326 alternating, 5208 clocks per 16 periods
        @(negedge clk);
        en = 1'b1;
        m_int = 325; m_frac = 8; m_acc = 0; m_phase = 0;
        push_periods(16);
        drain("dflt", 0, tot);
        check("dflt_total", tot, 5208);

        // Divisor table, each loaded while disabled then run for 16 periods
        foreach (vecs[i]) begin
            @(negedge clk);
            en = 1'b0;
            @(negedge clk);
            ld = 1'b1; di = vecs[i].d_int[15:0]; df = vecs[i].d_frac[3:0];
            @(negedge clk);
            ld = 1'b0;
            check($sformatf("vec%0d_err_on", i), int'(div_err), int'(vecs[i].exp_err));
            @(negedge clk);
            check($sformatf("vec%0d_err_off", i), int'(div_err), 0);
            if (!vecs[i].exp_err) begin
                m_int  = vecs[i].d_int;
                m_frac = vecs[i].d_frac;
            end
            en = 1'b1; m_acc = 0; m_phase = 0;
            push_periods(16);
            drain($sformatf("vec%0d", i), 0, tot);
            check($sformatf("vec%0d_total", i), tot, 16 * m_int + m_frac);
        end

        // Mid-period load of 10.0: current period keeps old length
        p = model_next_period();
        repeat (5) @(negedge clk);
        ld = 1'b1; di = 16'd10; df = 4'd0;
        q_exp.push_back(p);
        m_int = 10; m_frac = 0;
        push_periods(6);
        drain("midload", 5, tot);

        // Rejected load mid-period: error pulse, spacing unchanged
        repeat (3) @(negedge clk);
        ld = 1'b1; di = 16'd1; df = 4'd7;
        @(negedge clk);
        ld = 1'b0;
        check("rej_err_on", int'(div_err), 1);
        @(negedge clk);
        check("rej_err_off", int'(div_err), 0);
        push_periods(5);
        drain("rej", 5, tot);

        // Load on the boundary edge: active only after one more old period
        repeat (9) @(negedge clk);
        ld = 1'b1; di = 16'd6; df = 4'd0;
        push_periods(2);
        m_int = 6;
        push_periods(4);
        drain("bndload", 9, tot);

        // Disable one clock before a boundary, hold 20 clocks, re-enable
        repeat (5) @(negedge clk);
        en = 1'b0;
        ticks = 0;
        repeat (20) begin
            @(negedge clk);
            if (os_tick || tx_tick) ticks++;
        end
        check("dis_no_tick", ticks, 0);
        en = 1'b1; m_acc = 0; m_phase = 0;
        push_periods(18);
        drain("reen", 0, tot);

        // Asynchronous reset while a boundary load is pending in the shadow
        repeat (5) @(negedge clk);
        ld = 1'b1; di = 16'd10; df = 4'd0;
        @(negedge clk);
        ld = 1'b0;
        check("rst_pre_tick", int'(os_tick), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_os_tick", int'(os_tick), 0);
        check("arst_tx_tick", int'(tx_tick), 0);
        check("arst_div_err", int'(div_err), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_int = 325; m_frac = 8; m_acc = 0; m_phase = 0;
        push_periods(3);
        drain("postrst", 0, tot);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_tx_frac_baud_generator
`default_nettype wire
